// File: rtl/led_breather.sv
// Two-channel PWM "breathing" LED sequencer: triangle duty ramp with holds at
// full and zero brightness, the second channel running in antiphase.
module led_breather #(
    parameter int PWM_BITS     = 8,
    parameter int STEP_PERIODS = 250,
    parameter int HOLD_PERIODS = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [1:0] led,
    output logic       busy,
    output logic       cycle_done
);

    localparam int STEP_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam int HOLD_W = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;

    localparam logic [PWM_BITS-1:0] MAX       = {PWM_BITS{1'b1}};
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_PERIODS - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_PERIODS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD_HIGH = 3'd2,
        RAMP_DOWN = 3'd3,
        HOLD_LOW  = 3'd4
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty;
    logic [STEP_W-1:0]   step_cnt;
    logic [HOLD_W-1:0]   hold_cnt;

    logic                active;
    logic                in_hold;
    logic                period_end;
    logic                step;
    logic                hold_last;
    logic [1:0]          led_d;
    logic                busy_d;
    logic                cycle_done_d;

    assign active     = (state != IDLE);
    assign in_hold    = (state == HOLD_HIGH) || (state == HOLD_LOW);
    assign period_end = active && (pwm_cnt == MAX);
    assign step       = period_end && (step_cnt == STEP_LAST);
    assign hold_last  = in_hold && period_end && (hold_cnt == HOLD_LAST);

    // State register; the outputs are registered alongside it.
    // NOTE: sequential blocks use non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            led        <= 2'b00;
            busy       <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            state      <= next_state;
            led        <= led_d;
            busy       <= busy_d;
            cycle_done <= cycle_done_d;
        end
    end

    // NOTE: the default assignment up front keeps this block free of latches
    // even for state encodings the case does not list.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (en) next_state = RAMP_UP;
            RAMP_UP:   if (step && (duty == MAX)) next_state = HOLD_HIGH;
            HOLD_HIGH: if (hold_last) next_state = RAMP_DOWN;
            RAMP_DOWN: if (step && (duty == '0)) next_state = HOLD_LOW;
            HOLD_LOW:  if (hold_last) next_state = en ? RAMP_UP : IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        led_d[0]     = active && (pwm_cnt < duty);
        led_d[1]     = active && (pwm_cnt < (MAX - duty));
        busy_d       = (next_state != IDLE);
        cycle_done_d = (state == HOLD_LOW) && hold_last;
    end

    // PWM, step and hold counters plus the duty ramp; all parked at 0 in IDLE.
    always_ff @(posedge clk) begin
        if (rst || !active) begin
            pwm_cnt  <= '0;
            step_cnt <= '0;
            hold_cnt <= '0;
            duty     <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);

            // Re-align the step divider at the end of each hold so every ramp
            // starts with a full step interval.
            if (step || hold_last) begin
                step_cnt <= '0;
            end else if (period_end) begin
                step_cnt <= step_cnt + STEP_W'(1);
            end

            if (hold_last) begin
                hold_cnt <= '0;
            end else if (in_hold && period_end) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end

            case (state)
                RAMP_UP:   if (step && (duty != MAX)) duty <= duty + PWM_BITS'(1);
                RAMP_DOWN: if (step && (duty != '0))  duty <= duty - PWM_BITS'(1);
                HOLD_HIGH: duty <= MAX;
                default:   duty <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_led_breather.sv
// Scoreboard bench for led_breather: directed stimulus queues hand-computed
// per-cycle expectations; a negedge monitor pops and compares them.
module tb_led_breather;

    logic       clk = 1'b0;
    logic       rst_v  [2];
    logic       en_v   [2];
    logic [1:0] led_o  [2];
    logic       busy_o [2];
    logic       cd_o   [2];
    logic [2:0] duty_o [2];

    always #5 clk = ~clk;

    led_breather #(.PWM_BITS(3), .STEP_PERIODS(1), .HOLD_PERIODS(2)) u_dut0 (
        .clk        (clk),
        .rst        (rst_v[0]),
        .en         (en_v[0]),
        .led        (led_o[0]),
        .busy       (busy_o[0]),
        .cycle_done (cd_o[0])
    );

    led_breather #(.PWM_BITS(3), .STEP_PERIODS(2), .HOLD_PERIODS(2)) u_dut1 (
        .clk        (clk),
        .rst        (rst_v[1]),
        .en         (en_v[1]),
        .led        (led_o[1]),
        .busy       (busy_o[1]),
        .cycle_done (cd_o[1])
    );

    assign duty_o[0] = u_dut0.duty;
    assign duty_o[1] = u_dut1.duty;

    typedef struct {
        int         cyc;
        bit         chk_led;
        logic [1:0] led;
        logic       busy;
        logic       cd;
        bit         chk_duty;
        logic [2:0] duty;
        string      tag;
    } vec_t;

    vec_t       q [2][$];
    int         edge_n = 0;
    int         t0    [2];
    bit         armed [2];
    int         n_vec  = 0;
    int         n_miss = 0;
    logic [1:0] led_tab  [int];
    logic [2:0] duty_tab [int];

    always @(posedge clk) edge_n <= edge_n + 1;

    // Monitor: cycle k of a run is sampled on the negedge inside that cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (armed[i]) begin
                int rel;
                rel = edge_n - t0[i];
                while (q[i].size() != 0 && q[i][0].cyc <= rel) begin
                    vec_t v;
                    v = q[i].pop_front();
                    n_vec++;
                    if (v.cyc != rel || busy_o[i] !== v.busy || cd_o[i] !== v.cd ||
                        (v.chk_led && led_o[i] !== v.led) ||
                        (v.chk_duty && duty_o[i] !== v.duty)) begin
                        n_miss++;
                        $display("FAIL %s dut%0d cycle %0d (sampled at %0d): got led=%b busy=%b cycle_done=%b duty=%0d, want led=%b busy=%b cycle_done=%b duty=%0d",
                                 v.tag, i, v.cyc, rel, led_o[i], busy_o[i], cd_o[i], duty_o[i],
                                 v.led, v.busy, v.cd, v.duty);
                    end
                end
            end
        end
    end

    task automatic push(input int i, input int c, input bit cl, input logic [1:0] l,
                        input logic b, input logic d, input bit cdu, input logic [2:0] du,
                        input string tag);
        vec_t v;
        v.cyc = c; v.chk_led = cl; v.led = l; v.busy = b; v.cd = d;
        v.chk_duty = cdu; v.duty = du; v.tag = tag;
        q[i].push_back(v);
    endtask

    // Push one breath-relative cycle c (0..159) of dut0, using the hand tables.
    task automatic push_breath(input int abs_c, input int c, input logic cd, input string tag);
        push(0, abs_c, led_tab.exists(c), led_tab.exists(c) ? led_tab[c] : 2'b00, 1'b1, cd,
             duty_tab.exists(c), duty_tab.exists(c) ? duty_tab[c] : 3'd0, tag);
    endtask

    task automatic do_reset(input int i);
        armed[i] = 1'b0;
        @(negedge clk);
        en_v[i]  = 1'b0;
        rst_v[i] = 1'b1;
        repeat (2) @(negedge clk);
        rst_v[i] = 1'b0;
    endtask

    // Cycle 0 is the cycle right after the edge that follows this call.
    task automatic mark(input int i);
        @(posedge clk);
        #1;
        t0[i]    = edge_n;
        armed[i] = 1'b1;
    endtask

    task automatic start(input int i);
        @(negedge clk);
        en_v[i] = 1'b1;
        mark(i);
    endtask

    task automatic drain(input int i, input int budget);
        for (int k = 0; k < budget && q[i].size() != 0; k++) @(posedge clk);
        if (q[i].size() != 0) begin
            n_miss++;
            $display("FAIL drain dut%0d: %0d vectors never reached, want 0", i, q[i].size());
            q[i].delete();
        end
        @(posedge clk);
        armed[i] = 1'b0;
    endtask

    // Duty profile for STEP_PERIODS=2: 16-cycle steps, 16-cycle holds, L=288.
    function automatic logic [2:0] duty_step2(input int c);
        int p;
        p = c % 288;
        if (p < 128) return 3'(p / 16);
        if (p < 144) return 3'd7;
        if (p < 272) return 3'(7 - (p - 144) / 16);
        return 3'd0;
    endfunction

    initial begin
        rst_v[0] = 1'b1; rst_v[1] = 1'b1;
        en_v[0]  = 1'b0; en_v[1]  = 1'b0;
        armed[0] = 1'b0; armed[1] = 1'b0;

        // Hand-derived LED/duty values for one 160-cycle breath (led lags by 1).
        led_tab[0]  = 2'b00; led_tab[1]  = 2'b10;
        led_tab[24] = 2'b00; led_tab[25] = 2'b11; led_tab[26] = 2'b11; led_tab[27] = 2'b11;
        led_tab[28] = 2'b10; led_tab[29] = 2'b00; led_tab[30] = 2'b00; led_tab[31] = 2'b00;
        led_tab[63] = 2'b01;
        for (int c = 64; c <= 80; c++) led_tab[c] = (((c - 1) % 8) == 7) ? 2'b00 : 2'b01;
        led_tab[87]  = 2'b01; led_tab[95]  = 2'b00; led_tab[129] = 2'b11;
        led_tab[137] = 2'b10; led_tab[143] = 2'b10; led_tab[144] = 2'b00;
        led_tab[151] = 2'b10; led_tab[159] = 2'b10;
        duty_tab[0]  = 3'd0; duty_tab[24] = 3'd3; duty_tab[63] = 3'd7; duty_tab[64] = 3'd7;
        duty_tab[70] = 3'd7; duty_tab[79] = 3'd7; duty_tab[80] = 3'd7; duty_tab[88] = 3'd6;
        duty_tab[143] = 3'd0; duty_tab[144] = 3'd0; duty_tab[159] = 3'd0;

        // 1: idle with en low.
        do_reset(0);
        mark(0);
        for (int c = 0; c < 20; c++) push(0, c, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 3'd0, "idle");
        drain(0, 100);

        // 2: en held high for two breaths.
        do_reset(0);
        start(0);
        for (int c = 0; c <= 321; c++) push_breath(c, c % 160, (c == 160) || (c == 320), "run");
        drain(0, 1000);

        // 3: single-cycle en pulse.
        do_reset(0);
        start(0);
        en_v[0] = 1'b0;
        for (int c = 0; c <= 180; c++) begin
            if (c <= 160) push_breath(c, c % 160, c == 160, "pulse");
            else          push(0, c, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 3'd0, "pulse_idle");
        end
        q[0][160].busy = 1'b0;
        drain(0, 1000);

        // 4: en dropped mid ramp-up.
        do_reset(0);
        start(0);
        for (int c = 0; c <= 200; c++) begin
            if (c <= 160) push_breath(c, c % 160, c == 160, "drop");
            else          push(0, c, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 3'd0, "drop_idle");
        end
        q[0][160].busy = 1'b0;
        repeat (50) @(posedge clk);
        #1 en_v[0] = 1'b0;
        drain(0, 1000);

        // 5: reset during HOLD_HIGH, then restart from cycle 74.
        do_reset(0);
        start(0);
        for (int c = 0; c <= 236; c++) begin
            if (c <= 70)      push_breath(c, c, 1'b0, "pre_rst");
            else if (c <= 73) push(0, c, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 3'd0, "in_rst");
            else              push_breath(c, (c - 74) % 160, c == 234, "post_rst");
        end
        repeat (70) @(posedge clk);
        #1 rst_v[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_v[0] = 1'b0;
        drain(0, 1000);

        // 6: STEP_PERIODS=2 over three breaths, duty tracked every cycle.
        do_reset(1);
        start(1);
        for (int c = 0; c <= 866; c++)
            push(1, c, c == 0, 2'b00, 1'b1, (c != 0) && ((c % 288) == 0), 1'b1, duty_step2(c), "step2");
        drain(1, 2000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
